// File: rtl/image_rom_arbiter.sv
// Single-port image ROM shared by a VGA display stream (absolute priority) and an auxiliary read port.
// Define IMAGE_ROM_ARB_STATS_EN to add the aux_stall_cnt output counting aux cycles blocked by the display.
module image_rom_arbiter #(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter logic [3:0]  BORDER = 4'h0,
  localparam int unsigned ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_active,
  input  logic [9:0]        disp_x,
  input  logic [9:0]        disp_y,
  input  logic              disp_hsync,
  input  logic              disp_vsync,
  output logic [3:0]        disp_pixel,
  output logic              disp_de,
  output logic              disp_hsync_o,
  output logic              disp_vsync_o,
  input  logic              aux_req_valid,
  input  logic [ADDR_W-1:0] aux_addr,
  output logic              aux_req_ready,
  output logic              aux_rsp_valid,
  output logic [3:0]        aux_pixel,
  output logic              aux_rsp_err,
  input  logic              aux_rsp_ready,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_pixel
`ifdef IMAGE_ROM_ARB_STATS_EN
  ,
  output logic [15:0]       aux_stall_cnt
`endif
);

  localparam logic [ADDR_W:0]   NUM_PIX = (ADDR_W + 1)'(IMG_W * IMG_H);
  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic              disp_hit;
  logic [ADDR_W-1:0] disp_addr;
  logic              aux_accept;

  // Display pipeline: stage 1 waits for ROM data, stage 2 drives the outputs.
  logic       s1_hit_q, s1_hit_d;
  logic       s1_active_q, s1_active_d;
  logic       s1_hsync_q, s1_hsync_d;
  logic       s1_vsync_q, s1_vsync_d;
  logic [3:0] disp_pixel_q, disp_pixel_d;
  logic       disp_de_q, disp_de_d;
  logic       disp_hsync_o_q, disp_hsync_o_d;
  logic       disp_vsync_o_q, disp_vsync_o_d;

  logic [1:0] state_q, state_d;
  logic       err_pend_q, err_pend_d;
  logic [3:0] aux_pixel_q, aux_pixel_d;
  logic       aux_rsp_err_q, aux_rsp_err_d;

  assign disp_hit   = disp_active && (32'(disp_x) < IMG_W) && (32'(disp_y) < IMG_H);
  assign disp_addr  = ADDR_W'(disp_y) * IMG_W_A + ADDR_W'(disp_x);

  assign aux_req_ready = (state_q == S_IDLE) && !disp_hit;
  assign aux_accept    = aux_req_valid && aux_req_ready;

  always_comb begin
    rom_addr = '0;
    if (disp_hit) begin
      rom_addr = disp_addr;
    end else if (aux_accept) begin
      rom_addr = aux_addr;
    end
  end

  always_comb begin
    s1_hit_d       = disp_hit;
    s1_active_d    = disp_active;
    s1_hsync_d     = disp_hsync;
    s1_vsync_d     = disp_vsync;
    disp_pixel_d   = 4'h0;
    if (s1_hit_q) begin
      disp_pixel_d = rom_pixel;
    end else if (s1_active_q) begin
      disp_pixel_d = BORDER;
    end
    disp_de_d      = s1_active_q;
    disp_hsync_o_d = s1_hsync_q;
    disp_vsync_o_d = s1_vsync_q;
  end

  // Out-of-range addresses are still accepted; the error flag is latched at acceptance.
  always_comb begin
    state_d       = state_q;
    err_pend_d    = err_pend_q;
    aux_pixel_d   = aux_pixel_q;
    aux_rsp_err_d = aux_rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (aux_accept) begin
          state_d    = S_FETCH;
          err_pend_d = ({1'b0, aux_addr} >= NUM_PIX);
        end
      end
      S_FETCH: begin
        aux_pixel_d   = err_pend_q ? 4'h0 : rom_pixel;
        aux_rsp_err_d = err_pend_q;
        state_d       = S_RESP;
      end
      S_RESP: begin
        if (aux_rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hit_q       <= 1'b0;
      s1_active_q    <= 1'b0;
      s1_hsync_q     <= 1'b0;
      s1_vsync_q     <= 1'b0;
      disp_pixel_q   <= 4'h0;
      disp_de_q      <= 1'b0;
      disp_hsync_o_q <= 1'b0;
      disp_vsync_o_q <= 1'b0;
      state_q        <= S_IDLE;
      err_pend_q     <= 1'b0;
      aux_pixel_q    <= 4'h0;
      aux_rsp_err_q  <= 1'b0;
    end else begin
      s1_hit_q       <= s1_hit_d;
      s1_active_q    <= s1_active_d;
      s1_hsync_q     <= s1_hsync_d;
      s1_vsync_q     <= s1_vsync_d;
      disp_pixel_q   <= disp_pixel_d;
      disp_de_q      <= disp_de_d;
      disp_hsync_o_q <= disp_hsync_o_d;
      disp_vsync_o_q <= disp_vsync_o_d;
      state_q        <= state_d;
      err_pend_q     <= err_pend_d;
      aux_pixel_q    <= aux_pixel_d;
      aux_rsp_err_q  <= aux_rsp_err_d;
    end
  end

  assign disp_pixel    = disp_pixel_q;
  assign disp_de       = disp_de_q;
  assign disp_hsync_o  = disp_hsync_o_q;
  assign disp_vsync_o  = disp_vsync_o_q;
  assign aux_rsp_valid = (state_q == S_RESP);
  assign aux_pixel     = aux_pixel_q;
  assign aux_rsp_err   = aux_rsp_err_q;

`ifdef IMAGE_ROM_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (aux_req_valid && (state_q == S_IDLE) && disp_hit && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign aux_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Randomized bench for image_rom_arbiter: a transaction-level model checked every cycle plus hand-computed cases.
// Covers the IMAGE_ROM_ARB_STATS_EN counter when that macro is defined.
module tb_image_rom_arbiter;

  localparam int          W    = 640;
  localparam int          H    = 480;
  localparam int          AW   = 19;
  localparam int          NPIX = W * H;
  localparam logic [3:0]  BRD  = 4'hA;

  logic          clk;
  logic          rst;
  logic          disp_active;
  logic [9:0]    disp_x, disp_y;
  logic          disp_hsync, disp_vsync;
  logic [3:0]    disp_pixel;
  logic          disp_de, disp_hsync_o, disp_vsync_o;
  logic          aux_req_valid;
  logic [AW-1:0] aux_addr;
  logic          aux_req_ready;
  logic          aux_rsp_valid;
  logic [3:0]    aux_pixel;
  logic          aux_rsp_err;
  logic          aux_rsp_ready;
  logic [AW-1:0] rom_addr;
  logic [3:0]    rom_pixel;
`ifdef IMAGE_ROM_ARB_STATS_EN
  logic [15:0]   aux_stall_cnt;
`endif

  image_rom_arbiter #(.IMG_W(W), .IMG_H(H), .BORDER(BRD)) dut (
    .clk(clk), .rst(rst),
    .disp_active(disp_active), .disp_x(disp_x), .disp_y(disp_y),
    .disp_hsync(disp_hsync), .disp_vsync(disp_vsync),
    .disp_pixel(disp_pixel), .disp_de(disp_de),
    .disp_hsync_o(disp_hsync_o), .disp_vsync_o(disp_vsync_o),
    .aux_req_valid(aux_req_valid), .aux_addr(aux_addr), .aux_req_ready(aux_req_ready),
    .aux_rsp_valid(aux_rsp_valid), .aux_pixel(aux_pixel), .aux_rsp_err(aux_rsp_err),
    .aux_rsp_ready(aux_rsp_ready),
    .rom_addr(rom_addr), .rom_pixel(rom_pixel)
`ifdef IMAGE_ROM_ARB_STATS_EN
    , .aux_stall_cnt(aux_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents are a cheap hash of the address so expectations can be worked out by hand.
  function automatic logic [3:0] rom_fn(input logic [AW-1:0] a);
    logic [AW-1:0] s;
    s = a + (a >> 4) + (a >> 8) + AW'(3);
    return s[3:0];
  endfunction

  always @(posedge clk) rom_pixel <= rom_fn(rom_addr);

  int check_cnt = 0;
  int pass_cnt  = 0;
  bit chk_en    = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic bit model_hit(input logic a, input logic [9:0] x, input logic [9:0] y);
    return a && (int'(x) < W) && (int'(y) < H);
  endfunction

  typedef struct packed {
    logic [3:0] pix;
    logic       de;
    logic       hs;
    logic       vs;
  } disp_t;

  // Model state: display outputs appear two edges after the inputs are sampled;
  // an aux transaction is outstanding from acceptance until its response is taken.
  disp_t         exp_new, exp_old;
  bit            m_busy = 1'b0;
  int            m_acc  = 0;
  logic [AW-1:0] m_addr = '0;
  int            m_stall = 0;
  int            cyc = 0;
  bit            hit_p, hit_n, exp_v;
  logic [AW-1:0] exp_rom_addr;

  always @(posedge clk) begin
    hit_p = model_hit(disp_active, disp_x, disp_y);
    if (rst) begin
      m_busy  = 1'b0;
      m_stall = 0;
      exp_old = '0;
      exp_new = '0;
    end else begin
      exp_old     = exp_new;
      exp_new.pix = hit_p ? rom_fn(AW'(int'(disp_y) * W + int'(disp_x))) : (disp_active ? BRD : 4'h0);
      exp_new.de  = disp_active;
      exp_new.hs  = disp_hsync;
      exp_new.vs  = disp_vsync;
      if (m_busy) begin
        if (cyc >= m_acc + 2 && aux_rsp_ready) m_busy = 1'b0;
      end else if (aux_req_valid && !hit_p) begin
        m_busy = 1'b1;
        m_acc  = cyc;
        m_addr = aux_addr;
      end else if (aux_req_valid && hit_p && m_stall < 65535) begin
        m_stall++;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      hit_n = model_hit(disp_active, disp_x, disp_y);
      checkOutput("disp_pixel", 32'(disp_pixel), 32'(exp_old.pix));
      checkOutput("disp_de", 32'(disp_de), 32'(exp_old.de));
      checkOutput("disp_hsync_o", 32'(disp_hsync_o), 32'(exp_old.hs));
      checkOutput("disp_vsync_o", 32'(disp_vsync_o), 32'(exp_old.vs));
      checkOutput("aux_req_ready", 32'(aux_req_ready), 32'(!m_busy && !hit_n));
      exp_v = m_busy && (cyc >= m_acc + 2);
      checkOutput("aux_rsp_valid", 32'(aux_rsp_valid), 32'(exp_v));
      if (exp_v) begin
        checkOutput("aux_pixel", 32'(aux_pixel), (int'(m_addr) < NPIX) ? 32'(rom_fn(m_addr)) : 32'd0);
        checkOutput("aux_rsp_err", 32'(aux_rsp_err), 32'(int'(m_addr) >= NPIX));
      end
      if (hit_n) exp_rom_addr = AW'(int'(disp_y) * W + int'(disp_x));
      else if (!m_busy && aux_req_valid) exp_rom_addr = aux_addr;
      else exp_rom_addr = '0;
      checkOutput("rom_addr", 32'(rom_addr), 32'(exp_rom_addr));
`ifdef IMAGE_ROM_ARB_STATS_EN
      checkOutput("aux_stall_cnt", 32'(aux_stall_cnt), 32'(m_stall));
`endif
    end
  end

  task automatic applyStimulus(input bit r, input bit a, input int x, input int y, input bit hs,
                               input bit vs, input bit rv, input int addr, input bit rr);
    @(posedge clk);
    #2;
    rst           = r;
    disp_active   = a;
    disp_x        = 10'(x);
    disp_y        = 10'(y);
    disp_hsync    = hs;
    disp_vsync    = vs;
    aux_req_valid = rv;
    aux_addr      = AW'(addr);
    aux_rsp_ready = rr;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; disp_active = 1'b0; disp_x = '0; disp_y = '0; disp_hsync = 1'b1; disp_vsync = 1'b1;
    aux_req_valid = 1'b0; aux_addr = '0; aux_rsp_ready = 1'b0;
    repeat (3) applyStimulus(1, 0, 0, 0, 1, 1, 0, 0, 0);
    chk_en = 1'b1;
    @(negedge clk);
    checkOutput("rst_disp_de", 32'(disp_de), 32'd0);
    checkOutput("rst_disp_pixel", 32'(disp_pixel), 32'd0);
    checkOutput("rst_hsync_o", 32'(disp_hsync_o), 32'd0);
    checkOutput("rst_aux_rsp_valid", 32'(aux_rsp_valid), 32'd0);
    checkOutput("rst_aux_pixel", 32'(aux_pixel), 32'd0);

    // Pixel (5,2) lives at 2*640+5 = 1285; rom_fn(1285) = 13.
    applyStimulus(0, 1, 5, 2, 1, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("lit_rom_addr_1285", 32'(rom_addr), 32'd1285);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("lit_disp_pixel_1285", 32'(disp_pixel), 32'd13);
    checkOutput("lit_disp_de", 32'(disp_de), 32'd1);
    checkOutput("lit_hsync_delay", 32'(disp_hsync_o), 32'd1);

    // x=700 is outside the image: aux wins the ROM that cycle; rom_fn(1000) = 12.
    applyStimulus(0, 1, 700, 10, 0, 0, 1, 1000, 1);
    @(negedge clk);
    checkOutput("lit_ready_border", 32'(aux_req_ready), 32'd1);
    checkOutput("lit_rom_addr_1000", 32'(rom_addr), 32'd1000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("lit_valid_t1", 32'(aux_rsp_valid), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("lit_border_pixel", 32'(disp_pixel), 32'(BRD));
    checkOutput("lit_border_de", 32'(disp_de), 32'd1);
    checkOutput("lit_valid_t2", 32'(aux_rsp_valid), 32'd1);
    checkOutput("lit_aux_pixel_1000", 32'(aux_pixel), 32'd12);
    checkOutput("lit_aux_err_0", 32'(aux_rsp_err), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("lit_idle_t3", 32'(aux_req_ready), 32'd1);

    // Back-pressure: response held while a second request waits.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1285, 0);
    @(negedge clk);
    checkOutput("lit_bp_accept", 32'(aux_req_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, 0);
      @(negedge clk);
      checkOutput("lit_bp_ready", 32'(aux_req_ready), 32'd0);
      if (i >= 1) checkOutput("lit_bp_pixel", 32'(aux_pixel), 32'd13);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, 1);
    @(negedge clk);
    checkOutput("lit_bp_ready_handshake", 32'(aux_req_ready), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("lit_bp_released", 32'(aux_rsp_valid), 32'd0);

    // 307200 is one past the last pixel.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 307200, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("lit_oor_valid", 32'(aux_rsp_valid), 32'd1);
    checkOutput("lit_oor_pixel", 32'(aux_pixel), 32'd0);
    checkOutput("lit_oor_err", 32'(aux_rsp_err), 32'd1);

    // Reset during FETCH discards the transaction.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1000, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      checkOutput("lit_rst_fetch_no_rsp", 32'(aux_rsp_valid), 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 5 + i, 2, 0, 0, 1, 1000, 0);
      @(negedge clk);
      checkOutput("lit_stall_ready", 32'(aux_req_ready), 32'd0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef IMAGE_ROM_ARB_STATS_EN
    checkOutput("lit_stall_cnt_5", 32'(aux_stall_cnt), 32'd5);
`endif
    checkOutput("lit_stall_no_rsp", 32'(aux_rsp_valid), 32'd0);

    for (int n = 0; n < 2000; n++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                    $urandom_range(0, 799), $urandom_range(0, 524),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2) != 0,
                    ($urandom_range(0, 7) == 0) ? NPIX + int'($urandom_range(0, 524287 - NPIX))
                                                : int'($urandom_range(0, NPIX - 1)),
                    1'($urandom_range(0, 1)));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
